// File: rtl/insn_fetch_unit_pkg.sv
// Shared decode constants and default widths for the instruction-fetch slice.
package insn_fetch_unit_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int INSN_W_DEF = 32;

    // Opcode field position inside an instruction word.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    // R-type instructions are identified purely by an all-zero opcode.
    function automatic logic is_rtype(input logic [4:0] opcode);
        return opcode == OP_RTYPE;
    endfunction

endpackage

// File: rtl/insn_fetch_unit_fetch_fifo.sv
// Small synchronous fetch buffer with a single-cycle flush.
// Depth is a power of two so the pointers wrap by natural overflow.
module fetch_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_data_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the storage array has no reset; occupancy lives in count_q, so stale
    // words are never observable and the array can map onto plain flops/LUTRAM.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/insn_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read per cycle under a
// credit rule that guarantees buffer space for every return, and hands the
// buffered words to decode with the opcode pre-extracted.
module insn_fetch_unit
    import insn_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INSN_W     = INSN_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_insn,
    output logic [ADDR_W-1:0] out_pc,
    output logic [4:0]        out_opcode,
    output logic              out_isR
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int USED_W = CNT_W + 1;
    localparam int ENT_W  = INSN_W + ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] issued_pc_q;

    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  head_data;
    logic              head_valid;
    logic              pop_raw;
    logic              pop;
    logic              push;
    logic              issue;
    logic [USED_W-1:0] credits_used;

    assign head_valid = (fifo_count != '0);

    // Decode's acceptance; a redirect or reset in the same cycle cancels it.
    assign pop_raw = head_valid & out_ready;
    assign pop     = pop_raw & ~redirect_valid & ~reset;

    // Slots already claimed (buffered + in flight) after this cycle's pop.
    assign credits_used = USED_W'(fifo_count) + USED_W'(inflight_q) - USED_W'(pop_raw);
    assign issue = ~reset & ~redirect_valid & (credits_used < USED_W'(FIFO_DEPTH));

    // A return is kept only if nothing younger has flushed the stage.
    assign push = inflight_q & ~redirect_valid & ~reset;

    // Next PC: a redirect overrides sequential advance; the PC wraps naturally.
    // NOTE: always_comb assigns pc_d a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)  pc_d = redirect_pc;
        else if (issue)      pc_d = pc_q + ADDR_W'(1);
    end

    // PC and in-flight tracking; reset takes precedence over any redirect.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
        end
    end

    // Remember which PC the outstanding read belongs to; only meaningful while inflight_q.
    always_ff @(posedge clock) begin
        if (issue) issued_pc_q <= pc_q;
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ({imem_rdata, issued_pc_q}),
        .pop_i       (pop),
        .head_data_o (head_data),
        .count_o     (fifo_count)
    );

    // All outputs are forced low while reset is held.
    assign imem_req   = issue;
    assign imem_addr  = reset ? '0 : pc_q;
    assign out_valid  = ~reset & head_valid;
    assign out_insn   = reset ? '0 : head_data[ENT_W-1:ADDR_W];
    assign out_pc     = reset ? '0 : head_data[ADDR_W-1:0];
    assign out_opcode = out_insn[OPCODE_MSB:OPCODE_LSB];
    assign out_isR    = ~reset & is_rtype(out_opcode);

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Self-checking bench for insn_fetch_unit: directed scenarios plus a randomized
// run against a stream-level reference model.
module tb_insn_fetch_unit;

    localparam int ADDR_W = 12;
    localparam int INSN_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INSN_W-1:0] imem_rdata = '0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [INSN_W-1:0] out_insn;
    logic [ADDR_W-1:0] out_pc;
    logic [4:0]        out_opcode;
    logic              out_isR;

    // Second instance with a reset PC near the top of the address space.
    logic              w_reset = 1'b1;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic [INSN_W-1:0] w_rdata = '0;
    logic              w_valid;
    logic              w_ready = 1'b0;
    logic [INSN_W-1:0] w_insn;
    logic [ADDR_W-1:0] w_pc;
    logic [4:0]        w_opcode;
    logic              w_isR;

    int n_vec = 0;
    int n_err = 0;
    int mem_mode = 0;

    always #5 clock = ~clock;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_f(input int mode, input logic [11:0] a);
        logic [31:0] w;
        w = {20'b0, a};
        case (mode)
            1:       return a[0] ? 32'h2800_0000 : w;
            2:       return w * 32'h9E37_79B1;
            default: return w * 3;
        endcase
    endfunction

    // Synchronous imem models with one-cycle read latency.
    always @(posedge clock) begin
        imem_rdata <= mem_f(mem_mode, imem_addr);
        w_rdata    <= mem_f(mem_mode, w_addr);
    end

    insn_fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc),
        .out_opcode     (out_opcode),
        .out_isR        (out_isR)
    );

    insn_fetch_unit #(.RESET_PC(12'hFFE)) dut_w (
        .clock          (clock),
        .reset          (w_reset),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (12'h000),
        .out_valid      (w_valid),
        .out_ready      (w_ready),
        .out_insn       (w_insn),
        .out_pc         (w_pc),
        .out_opcode     (w_opcode),
        .out_isR        (w_isR)
    );

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Two reset cycles; on return the next sampled cycle is cycle 1.
    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 12'h055;
        out_ready = 1'b1;
        step();
        step();
        @(negedge clock);
        n_vec++;
        if ({imem_req, imem_addr, out_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_issue: req=%b addr=%h valid=%b required all 0", imem_req, imem_addr, out_valid);
        end
        n_vec++;
        if ({out_insn, out_pc, out_opcode, out_isR} !== '0) begin
            n_err++;
            $display("FAIL reset_out: insn=%h pc=%h op=%b isR=%b required all 0", out_insn, out_pc, out_opcode, out_isR);
        end
        step();
        redirect_valid = 1'b0;
        reset = 1'b0;
        // The redirect seen during reset must not have moved the PC.
        @(negedge clock);
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
            n_err++;
            $display("FAIL reset_first_issue: req=%b addr=%h required 1/000", imem_req, imem_addr);
        end
        step();
    endtask

    // Free-running stream: req from cycle 1, data from cycle 3.
    task automatic test_stream();
        mem_mode = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 12'(c - 1)) begin
                n_err++;
                $display("FAIL stream_issue c%0d: req=%b addr=%h required 1/%h", c, imem_req, imem_addr, 12'(c - 1));
            end
            n_vec++;
            if (out_valid !== (c >= 3)) begin
                n_err++;
                $display("FAIL stream_valid c%0d: got %b required %b", c, out_valid, c >= 3);
            end
            if (c >= 3) begin
                n_vec++;
                if (out_pc !== 12'(c - 3) || out_insn !== 32'((c - 3) * 3)) begin
                    n_err++;
                    $display("FAIL stream_data c%0d: pc=%h insn=%h required %h/%h", c, out_pc, out_insn, 12'(c - 3), 32'((c - 3) * 3));
                end
            end
            step();
        end
    endtask

    // Backpressure: exactly two words buffered, head stable, nothing lost.
    task automatic test_backpressure();
        int nreq;
        mem_mode = 0;
        do_reset();
        out_ready = 1'b0;
        nreq = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (imem_req === 1'b1) nreq++;
            if (c >= 3) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_pc !== 12'h000 || out_insn !== 32'h0) begin
                    n_err++;
                    $display("FAIL bp_head c%0d: valid=%b pc=%h insn=%h required 1/000/0", c, out_valid, out_pc, out_insn);
                end
                n_vec++;
                if (imem_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_stall c%0d: req=%b required 0", c, imem_req);
                end
            end
            step();
        end
        n_vec++;
        if (nreq != 2) begin
            n_err++;
            $display("FAIL bp_req_count: got %0d required 2", nreq);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 12'(k) || out_insn !== 32'(k * 3)) begin
                n_err++;
                $display("FAIL bp_drain k%0d: valid=%b pc=%h insn=%h required 1/%h/%h", k, out_valid, out_pc, out_insn, 12'(k), 32'(k * 3));
            end
            step();
        end
    endtask

    // Check the output stream restarts at target with the T+3 latency.
    task automatic expect_restart(input string tag, input logic [11:0] tgt);
        for (int d = 1; d <= 5; d++) begin
            @(negedge clock);
            n_vec++;
            if (out_valid !== (d >= 3)) begin
                n_err++;
                $display("FAIL %s_valid T+%0d: got %b required %b", tag, d, out_valid, d >= 3);
            end
            if (d >= 3) begin
                n_vec++;
                if (out_pc !== tgt + 12'(d - 3) || out_insn !== mem_f(0, tgt + 12'(d - 3))) begin
                    n_err++;
                    $display("FAIL %s_data T+%0d: pc=%h insn=%h required %h/%h", tag, d, out_pc, out_insn, tgt + 12'(d - 3), mem_f(0, tgt + 12'(d - 3)));
                end
            end
            step();
        end
    endtask

    task automatic test_redirect();
        mem_mode = 0;
        do_reset();
        out_ready = 1'b0;
        step();
        step();
        // Cycle 3: one word buffered, one read returning this cycle.
        redirect_valid = 1'b1;
        redirect_pc = 12'h100;
        out_ready = 1'b1;
        @(negedge clock);
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL redir_req_T: got %b required 0", imem_req);
        end
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h100) begin
            n_err++;
            $display("FAIL redir_issue: req=%b addr=%h required 1/100", imem_req, imem_addr);
        end
        // expect_restart re-samples T+1, so rewind by starting from this cycle.
        step();
        for (int d = 2; d <= 5; d++) begin
            @(negedge clock);
            n_vec++;
            if (out_valid !== (d >= 3) || (d >= 3 && out_pc !== 12'h100 + 12'(d - 3))) begin
                n_err++;
                $display("FAIL redir_out T+%0d: valid=%b pc=%h required %b/%h", d, out_valid, out_pc, d >= 3, 12'h100 + 12'(d - 3));
            end
            step();
        end
        // Back-to-back redirects: the second target wins.
        redirect_valid = 1'b1;
        redirect_pc = 12'h200;
        step();
        redirect_pc = 12'h300;
        step();
        redirect_valid = 1'b0;
        expect_restart("b2b", 12'h300);
    endtask

    // PC wraps from 0xFFF to 0x000.
    task automatic test_wrap();
        logic [11:0] e;
        mem_mode = 0;
        w_reset = 1'b1;
        step();
        step();
        w_reset = 1'b0;
        w_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            e = 12'hFFE + 12'(c - 1);
            n_vec++;
            if (w_req !== 1'b1 || w_addr !== e) begin
                n_err++;
                $display("FAIL wrap_issue c%0d: req=%b addr=%h required 1/%h", c, w_req, w_addr, e);
            end
            if (c >= 3) begin
                e = 12'hFFE + 12'(c - 3);
                n_vec++;
                if (w_valid !== 1'b1 || w_pc !== e || w_insn !== mem_f(0, e)) begin
                    n_err++;
                    $display("FAIL wrap_out c%0d: valid=%b pc=%h insn=%h required 1/%h/%h", c, w_valid, w_pc, w_insn, e, mem_f(0, e));
                end
            end
            step();
        end
        w_reset = 1'b1;
    endtask

    task automatic test_opcode();
        mem_mode = 1;
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b1 || out_opcode !== 5'b00000 || out_isR !== 1'b1) begin
            n_err++;
            $display("FAIL opcode_rtype: valid=%b op=%b isR=%b required 1/00000/1", out_valid, out_opcode, out_isR);
        end
        step();
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b1 || out_insn !== 32'h2800_0000 || out_opcode !== 5'b00101 || out_isR !== 1'b0) begin
            n_err++;
            $display("FAIL opcode_imm: valid=%b insn=%h op=%b isR=%b required 1/28000000/00101/0", out_valid, out_insn, out_opcode, out_isR);
        end
        step();
        mem_mode = 0;
    endtask

    task automatic test_reset_mid();
        mem_mode = 0;
        do_reset();
        out_ready = 1'b0;
        for (int c = 1; c <= 6; c++) step();
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_during: valid=%b req=%b required 0/0", out_valid, imem_req);
        end
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 12'(c - 1)) begin
                n_err++;
                $display("FAIL rstmid_issue c%0d: req=%b addr=%h required 1/%h", c, imem_req, imem_addr, 12'(c - 1));
            end
            n_vec++;
            if (out_valid !== (c == 3) || (c == 3 && out_pc !== 12'h000)) begin
                n_err++;
                $display("FAIL rstmid_out c%0d: valid=%b pc=%h required %b/000", c, out_valid, out_pc, c == 3);
            end
            step();
        end
    endtask

    // Random run against a stream model: the decoder must see pc, pc+1, ...
    // from the last reset/redirect target, and the fetch unit must request
    // exactly when fewer than two words would be outstanding after this pop.
    task automatic test_random();
        logic [11:0] exp_pc, exp_issue, diff;
        logic [31:0] ew;
        int          outstanding, accepted;
        bit          last_req, exp_valid, exp_req, pop;
        mem_mode = 2;
        do_reset();
        exp_pc = 12'h000;
        exp_issue = 12'h000;
        last_req = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3)) : 12'($urandom);
            @(negedge clock);
            diff = exp_issue - exp_pc;
            outstanding = int'(diff);
            exp_valid = (outstanding - int'(last_req)) > 0;
            pop = exp_valid && out_ready;
            exp_req = !redirect_valid && (outstanding - int'(pop) < 2);
            n_vec++;
            if (out_valid !== exp_valid) begin
                n_err++;
                $display("FAIL rnd_valid cyc%0d: got %b required %b", cyc, out_valid, exp_valid);
            end
            n_vec++;
            if (imem_req !== exp_req) begin
                n_err++;
                $display("FAIL rnd_req cyc%0d: got %b required %b", cyc, imem_req, exp_req);
            end
            if (exp_req) begin
                n_vec++;
                if (imem_addr !== exp_issue) begin
                    n_err++;
                    $display("FAIL rnd_addr cyc%0d: got %h required %h", cyc, imem_addr, exp_issue);
                end
            end
            if (exp_valid) begin
                ew = mem_f(2, exp_pc);
                n_vec++;
                if (out_pc !== exp_pc || out_insn !== ew) begin
                    n_err++;
                    $display("FAIL rnd_head cyc%0d: pc=%h insn=%h required %h/%h", cyc, out_pc, out_insn, exp_pc, ew);
                end
                n_vec++;
                if (out_opcode !== ew[31:27] || out_isR !== (ew[31:27] == 5'b0)) begin
                    n_err++;
                    $display("FAIL rnd_decode cyc%0d: op=%b isR=%b required %b/%b", cyc, out_opcode, out_isR, ew[31:27], ew[31:27] == 5'b0);
                end
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                exp_issue = redirect_pc;
                last_req = 1'b0;
            end else begin
                if (pop) begin
                    exp_pc = exp_pc + 12'd1;
                    accepted++;
                end
                if (exp_req) exp_issue = exp_issue + 12'd1;
                last_req = exp_req;
            end
            step();
        end
        redirect_valid = 1'b0;
        n_vec++;
        if (accepted < 500) begin
            n_err++;
            $display("FAIL rnd_progress: accepted %0d required >= 500", accepted);
        end
        mem_mode = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_opcode();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
